// File: rtl/seq_det_pkg.sv
// seq_det_pkg: default constants and overlap mode encodings for prog_seq_detector
package seq_det_pkg;
  localparam int PAT_W_DEF = 5;
  localparam logic [4:0] PAT_RST_DEF = 5'b10101;
  localparam int CNT_W_DEF = 8;
  localparam logic MODE_NONOVL = 1'b0;
  localparam logic MODE_OVL = 1'b1;
endpackage

// File: rtl/seq_det_match_cnt.sv
// seq_det_match_cnt: saturating match counter with registered saturation flag, clear wins over inc
module seq_det_match_cnt
  import seq_det_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         sat
);
  logic [W-1:0] cnt_q, cnt_d;
  logic sat_q, sat_d;
  always_comb begin
    cnt_d = clr ? '0 : (inc && !sat_q) ? cnt_q + W'(1) : cnt_q;
    sat_d = &cnt_d;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end
  assign cnt = cnt_q;
  assign sat = sat_q;
endmodule

// File: rtl/prog_seq_detector.sv
// prog_seq_detector: programmable serial pattern detector, match counter present only with SEQ_DET_CNT_EN
module prog_seq_detector
  import seq_det_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(PAT_RST_DEF),
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             d_in,
  input  logic             d_valid,
  input  logic             overlap_en,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             cnt_clr,
  output logic             q_out,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);
  localparam int FW = $clog2(PAT_W);
  logic [PAT_W-1:0] pat_q, pat_d, win;
  logic [PAT_W-2:0] hist_q, hist_d;
  logic [FW-1:0] fill_q, fill_d;
  logic samp, full;
  assign samp = d_valid & ~pat_load;
  assign full = fill_q == FW'(PAT_W - 1);
  assign win = {hist_q, d_in};
  assign q_out = samp & reset_n & full & (win == pat_q);
  always_comb begin
    pat_d = pat_load ? pat_in : pat_q;
    hist_d = samp ? win[PAT_W-2:0] : hist_q;
    fill_d = pat_load ? '0 :
             !samp ? fill_q :
             (q_out && overlap_en == MODE_NONOVL) ? '0 :
             full ? fill_q : fill_q + FW'(1);
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pat_q <= PAT_RST;
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      pat_q <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end
`ifdef SEQ_DET_CNT_EN
  seq_det_match_cnt #(.W(CNT_W)) u_cnt (
    .clk(clk),
    .reset_n(reset_n),
    .inc(q_out),
    .clr(cnt_clr),
    .cnt(match_cnt),
    .sat(cnt_sat)
  );
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign match_cnt = '0;
  assign cnt_sat = 1'b0;
`endif
endmodule

// File: tb/tb_prog_seq_detector.sv
// tb_prog_seq_detector: table-driven check of prog_seq_detector plus a CNT_W=2 saturation sequence
module tb_prog_seq_detector;
  typedef struct {
    logic r, d, v, o, l;
    logic [4:0] p;
    logic c, q;
    int n;
  } vec_t;
`ifdef SEQ_DET_CNT_EN
  localparam bit CE = 1'b1;
`else
  localparam bit CE = 1'b0;
`endif
  logic clk = 1'b0, reset_n = 1'b0, d_in = 1'b0, d_valid = 1'b0, overlap_en = 1'b0;
  logic pat_load = 1'b0, cnt_clr = 1'b0;
  logic [4:0] pat_in = '0;
  logic qa, qb, sa, sb;
  logic [7:0] ca;
  logic [1:0] cb;
  int nv = 0, nf = 0;
  vec_t tv[$];
  always #5 clk = ~clk;
  prog_seq_detector dut_a (
    .clk(clk), .reset_n(reset_n), .d_in(d_in), .d_valid(d_valid), .overlap_en(overlap_en),
    .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr), .q_out(qa), .match_cnt(ca), .cnt_sat(sa)
  );
  prog_seq_detector #(.CNT_W(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .d_in(d_in), .d_valid(d_valid), .overlap_en(overlap_en),
    .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr), .q_out(qb), .match_cnt(cb), .cnt_sat(sb)
  );
  function automatic vec_t mk(logic r, d, v, o, l, logic [4:0] p, logic c, q, int n);
    vec_t t;
    t.r = r; t.d = d; t.v = v; t.o = o; t.l = l; t.p = p; t.c = c; t.q = q; t.n = n;
    return t;
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nv++;
    if (act !== exp) begin
      nf++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic drive(vec_t t);
    @(negedge clk);
    reset_n = t.r; d_in = t.d; d_valid = t.v; overlap_en = t.o;
    pat_load = t.l; pat_in = t.p; cnt_clr = t.c;
    #4;
  endtask
  task automatic post_edge();
    @(posedge clk);
    #1;
  endtask
  initial begin
    tv.push_back(mk(0,0,0,1,0,0,0,0,0));
    tv.push_back(mk(1,1,1,1,0,0,0,0,0));
    tv.push_back(mk(1,0,1,1,0,0,0,0,0));
    tv.push_back(mk(1,1,1,1,0,0,0,0,0));
    tv.push_back(mk(1,0,1,1,0,0,0,0,0));
    tv.push_back(mk(1,1,1,1,0,0,0,1,1));
    tv.push_back(mk(1,0,1,1,0,0,0,0,1));
    tv.push_back(mk(1,1,1,1,0,0,0,1,2));
    tv.push_back(mk(1,0,1,0,0,0,0,0,2));
    tv.push_back(mk(1,1,1,0,0,0,0,1,3));
    tv.push_back(mk(1,0,1,0,0,0,0,0,3));
    tv.push_back(mk(1,1,1,0,0,0,0,0,3));
    tv.push_back(mk(0,0,0,0,0,0,0,0,0));
    tv.push_back(mk(1,1,1,0,0,0,0,0,0));
    tv.push_back(mk(1,0,1,0,0,0,0,0,0));
    tv.push_back(mk(1,1,1,0,0,0,0,0,0));
    tv.push_back(mk(1,0,1,0,0,0,0,0,0));
    tv.push_back(mk(1,1,1,0,0,0,0,1,1));
    tv.push_back(mk(1,0,1,0,0,0,0,0,1));
    tv.push_back(mk(1,1,1,0,0,0,0,0,1));
    tv.push_back(mk(1,1,1,0,1,5'b11001,0,0,1));
    tv.push_back(mk(1,1,1,0,0,0,0,0,1));
    tv.push_back(mk(1,1,1,0,0,0,0,0,1));
    tv.push_back(mk(1,0,1,0,0,0,0,0,1));
    tv.push_back(mk(1,0,1,0,0,0,0,0,1));
    tv.push_back(mk(1,1,1,0,0,0,0,1,2));
    tv.push_back(mk(1,1,1,0,0,0,0,0,2));
    tv.push_back(mk(1,0,1,0,0,0,0,0,2));
    tv.push_back(mk(1,1,1,0,0,0,0,0,2));
    tv.push_back(mk(1,0,1,0,0,0,0,0,2));
    tv.push_back(mk(1,1,1,0,0,0,0,0,2));
    tv.push_back(mk(0,0,0,1,0,0,0,0,0));
    tv.push_back(mk(1,1,1,1,0,0,0,0,0));
    tv.push_back(mk(1,0,1,1,0,0,0,0,0));
    tv.push_back(mk(1,1,1,1,0,0,0,0,0));
    tv.push_back(mk(1,0,1,1,0,0,0,0,0));
    tv.push_back(mk(0,1,1,1,0,0,0,0,0));
    tv.push_back(mk(1,1,1,1,0,0,0,0,0));
    tv.push_back(mk(1,0,1,1,0,0,0,0,0));
    tv.push_back(mk(1,1,1,1,0,0,0,0,0));
    tv.push_back(mk(1,0,1,1,0,0,0,0,0));
    tv.push_back(mk(1,1,1,1,0,0,0,1,1));
    tv.push_back(mk(0,0,0,1,0,0,0,0,0));
    for (int b = 0; b < 5; b++) begin
      tv.push_back(mk(1,(b % 2 == 0),1,1,0,0,0,(b == 4),(b == 4)));
      if (b < 4)
        for (int g = 0; g < 3; g++) tv.push_back(mk(1,g[0],0,1,0,0,0,0,0));
    end
    foreach (tv[i]) begin
      drive(tv[i]);
      chk($sformatf("v%0d_q_out", i), 32'(qa), 32'(tv[i].q));
      post_edge();
      chk($sformatf("v%0d_match_cnt", i), 32'(ca), CE ? tv[i].n : 0);
      chk($sformatf("v%0d_cnt_sat", i), 32'(sa), 0);
    end
    drive(mk(0,0,0,1,0,0,0,0,0));
    post_edge();
    chk("b_rst_cnt", 32'(cb), 0);
    chk("b_rst_sat", 32'(sb), 0);
    for (int i = 1; i <= 13; i++) begin
      int m;
      drive(mk(1,i[0],1,1,0,0,0,0,0));
      chk($sformatf("b%0d_q_out", i), 32'(qb), 32'(i >= 5 && i[0]));
      post_edge();
      m = i >= 5 ? (i - 3) / 2 : 0;
      chk($sformatf("b%0d_match_cnt", i), 32'(cb), CE ? (m > 3 ? 3 : m) : 0);
      chk($sformatf("b%0d_cnt_sat", i), 32'(sb), 32'(CE && m >= 3));
    end
    drive(mk(1,0,1,1,0,0,0,0,0));
    chk("b_pre_q_out", 32'(qb), 0);
    post_edge();
    drive(mk(1,1,1,1,0,0,1,0,0));
    chk("b_clr_q_out", 32'(qb), 1);
    post_edge();
    chk("b_clr_match_cnt", 32'(cb), 0);
    chk("b_clr_cnt_sat", 32'(sb), 0);
    chk("a_clr_match_cnt", 32'(ca), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nv, nf);
    $finish;
  end
endmodule

// File: doc/prog_seq_detector.md
PROG_SEQ_DETECTOR -- requirements
Module: prog_seq_detector

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
  PAT_W, 5, pattern length in bits (2..16).
  PAT_RST, 5'b10101, pattern value loaded at reset.
  CNT_W, 8, match counter width.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
  clk  input  1  single clock; all state updates on the rising edge.
  reset_n  input  1  reset; synchronous and active-low.
  d_in  input  1  serial data bit.
  d_valid  input  1  d_in is sampled this cycle.
  overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping.
  pat_load  input  1  load pat_in as the new pattern.
  pat_in  input  PAT_W  new pattern; MSB is the first bit received.
  cnt_clr  input  1  clear the match counter.
  q_out  output  1  Mealy match pulse.
  match_cnt  output  CNT_W  number of matches, saturating.
  cnt_sat  output  1  match_cnt is at its maximum value.

Function
REQ-003 The block SHALL hold a pattern register pat_q, a PAT_W-1 bit history register hist_q, and a fill counter fill_q (0..PAT_W-1).
REQ-004 q_out SHALL be combinational (Mealy) and SHALL be 1 only when all of these hold:
  - d_valid=1, pat_load=0 and reset_n=1;
  - fill_q == PAT_W-1;
  - {hist_q, d_in} == pat_q.
REQ-005 On each clock with d_valid=1 and pat_load=0:
  - hist_q SHALL shift left with d_in entering at the LSB;
  - fill_q SHALL increment, saturating at PAT_W-1.
REQ-006 On a match with overlap_en=1, fill_q SHALL stay at PAT_W-1, so matching suffixes count (10101 followed by 01 gives 2 matches).
REQ-007 On a match with overlap_en=0, fill_q SHALL clear to 0, so the next match needs PAT_W fresh bits.
REQ-008 With d_valid=0, hist_q and fill_q SHALL hold and q_out SHALL be 0.
REQ-009 pat_load=1 SHALL load pat_in into pat_q and clear fill_q to 0 on that edge.
REQ-010 If pat_load and d_valid are both 1 in the same cycle, pat_load SHALL win, the sample SHALL be discarded and q_out SHALL be 0.
REQ-011 A change of overlap_en SHALL take effect on the next sample and SHALL NOT flush the history.
REQ-012 On a match, match_cnt SHALL increment by 1 on the same edge, saturating at 2^CNT_W-1.
REQ-013 cnt_sat SHALL equal (match_cnt == all ones), registered together with match_cnt.
REQ-014 cnt_clr SHALL set match_cnt to 0; if cnt_clr and a match occur in the same cycle, cnt_clr SHALL win (result 0).

Reset
REQ-015 With reset_n=0 at a rising edge, the block SHALL set pat_q=PAT_RST, hist_q=0, fill_q=0 and match_cnt=0.
REQ-016 During reset, q_out SHALL be 0 and cnt_sat SHALL be 0.
REQ-017 A reset mid-pattern SHALL discard partial history, so no match is reported until PAT_W new valid bits have arrived after reset release.

Configuration
REQ-018 With macro SEQ_DET_CNT_EN defined, the match counter logic SHALL be present and behave per REQ-012..REQ-014.
REQ-019 Without SEQ_DET_CNT_EN, match_cnt and cnt_sat SHALL be tied to 0, cnt_clr SHALL be ignored, no counter flops SHALL exist, and q_out SHALL behave identically.

Structure
REQ-020 Package seq_det_pkg SHALL hold:
  - default constants PAT_W_DEF=5, PAT_RST_DEF=5'b10101, CNT_W_DEF=8;
  - the overlap mode constants MODE_NONOVL=1'b0 and MODE_OVL=1'b1.
REQ-021 The saturating counter SHALL be a sub-module seq_det_match_cnt (ports: clk, reset_n, inc, clr, cnt, sat), instantiated only under SEQ_DET_CNT_EN.

Verification
REQ-022 The bench SHALL cover these directed scenarios (stimulus -> required response):
  - Defaults, overlap_en=1, stream 1,0,1,0,1,0,1 all valid -> q_out pulses on bits 5 and 7; match_cnt=2.
  - Same stream with overlap_en=0 -> single pulse on bit 5; match_cnt=1.
  - pat_load with pat_in=5'b11001, then stream 1,1,0,0,1 -> pulse on the 5th bit; then 1,0,1,0,1 -> no pulse.
  - Stream 1,0,1,0 then reset_n=0 for one cycle, then 1 -> no pulse; a fresh 10101 after release -> pulse.
  - Stream 1,0,1,0 with d_valid=0 gaps of 3 cycles between bits, then 1 -> exactly one pulse; q_out=0 in every gap cycle.
  - CNT_W=2 with 5 overlapping matches -> match_cnt stays at 3 and cnt_sat=1; cnt_clr together with a match -> match_cnt=0.
  - Repeat the first scenario without SEQ_DET_CNT_EN -> identical q_out; match_cnt=0.
